// File: rtl/ddr3_dqs_trainer_pkg.sv
// Shared types and helpers for the DDR3 read-DQS delay-line trainer.
package ddr3_dqs_trainer_pkg;

    localparam int CALC_W = 16;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        CLEAR,
        SETTLE,
        SAMPLE,
        EVAL,
        STEP,
        CENTER_LOAD,
        CENTER_MOVE,
        NEXT,
        FIN
    } trainer_state_t;

    // Centre of a window, rounding toward the start when the length is even.
    function automatic logic [CALC_W-1:0] centre_tap(
        input logic [CALC_W-1:0] best_start,
        input logic [CALC_W:0]   best_len
    );
        logic [CALC_W:0] half;
        half = (best_len - (CALC_W+1)'(1)) >> 1;
        return best_start + half[CALC_W-1:0];
    endfunction

endpackage

// File: rtl/ddr3_dqs_window_tracker.sv
// Tracks the current passing run and the longest passing window seen during one lane's sweep.
module ddr3_dqs_window_tracker #(
    parameter int TAP_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             eval,
    input  logic             pass,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W:0]   best_len,
    output logic [TAP_W-1:0] best_start
);

    logic [TAP_W:0]   run_len;
    logic [TAP_W:0]   run_len_inc;
    logic [TAP_W-1:0] run_start;
    logic [TAP_W-1:0] run_start_cur;

    // The run that includes this tap is compared right away, so a window ending at the last tap still counts.
    always_comb begin
        run_len_inc   = run_len + (TAP_W+1)'(1);
        run_start_cur = (run_len == '0) ? tap : run_start;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
        end else if (eval) begin
            if (pass) begin
                run_len   <= run_len_inc;
                run_start <= run_start_cur;
                if (run_len_inc > best_len) begin
                    best_len   <= run_len_inc;
                    best_start <= run_start_cur;
                end
            end else begin
                run_len <= '0;
            end
        end
    end

endmodule

// File: rtl/ddr3_dqs_delay_trainer.sv
// Sweeps each lane's IOD read-DQS delay line, finds the longest passing eye window and parks the line at its centre.
module ddr3_dqs_delay_trainer
    import ddr3_dqs_trainer_pkg::*;
#(
    parameter int NUM_LANES     = 2,
    parameter int TAP_W         = 7,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_CYCLES = 16
) (
    input  logic                       FAB_CLK,
    input  logic                       SYNC_RST,
    input  logic                       START,
    input  logic [NUM_LANES-1:0]       EYE_MONITOR_EARLY,
    input  logic [NUM_LANES-1:0]       EYE_MONITOR_LATE,
    input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [NUM_LANES-1:0]       LANE_FAIL,
    output logic [NUM_LANES*TAP_W-1:0] LANE_TAP
);

    localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [TAP_W-1:0]  TAP_MAX     = '1;
    localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(NUM_LANES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);

    trainer_state_t state;
    trainer_state_t state_next;

    logic [LANE_W-1:0]    lane;
    logic [TAP_W-1:0]     tap;
    logic [TAP_W-1:0]     pos;
    logic [TAP_W-1:0]     centre;
    logic [CNT_W-1:0]     cnt;
    logic                 fail_bit;
    logic                 move_gap;
    logic [NUM_LANES-1:0] lane_mask;
    logic                 move_pulse;
    logic                 load_pulse;
    logic                 clear_pulse;
    logic [TAP_W:0]       best_len;
    logic [TAP_W-1:0]     best_start;

    ddr3_dqs_window_tracker #(
        .TAP_W(TAP_W)
    ) u_window_tracker (
        .clk       (FAB_CLK),
        .rst       (SYNC_RST),
        .clear     (state == LOAD),
        .eval      (state == EVAL),
        .pass      (~fail_bit),
        .tap       (tap),
        .best_len  (best_len),
        .best_start(best_start)
    );

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        move_pulse  = 1'b0;
        load_pulse  = 1'b0;
        clear_pulse = 1'b0;
        case (state)
            IDLE:        if (START) state_next = LOAD;
            LOAD: begin
                load_pulse = 1'b1;
                state_next = CLEAR;
            end
            CLEAR: begin
                clear_pulse = 1'b1;
                state_next  = SETTLE;
            end
            SETTLE:      if (cnt == SETTLE_LAST) state_next = SAMPLE;
            SAMPLE:      if (cnt == SAMPLE_LAST) state_next = EVAL;
            EVAL: begin
                if (tap == TAP_MAX || DELAY_LINE_OUT_OF_RANGE[lane]) state_next = CENTER_LOAD;
                else                                                  state_next = STEP;
            end
            STEP: begin
                move_pulse = 1'b1;
                state_next = CLEAR;
            end
            CENTER_LOAD: begin
                load_pulse = 1'b1;
                state_next = (best_len == '0) ? NEXT : CENTER_MOVE;
            end
            CENTER_MOVE: begin
                if (pos == centre) state_next = NEXT;
                else               move_pulse = ~move_gap;
            end
            NEXT:        state_next = (lane == LAST_LANE) ? FIN : LOAD;
            FIN:         state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    // Datapath for the sweep, centring and per-lane result registers.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            lane      <= '0;
            tap       <= '0;
            pos       <= '0;
            centre    <= '0;
            cnt       <= '0;
            fail_bit  <= 1'b0;
            move_gap  <= 1'b0;
            LANE_FAIL <= '0;
            LANE_TAP  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        LANE_FAIL <= '0;
                        LANE_TAP  <= '0;
                        lane      <= '0;
                    end
                end
                LOAD:   tap <= '0;
                CLEAR: begin
                    fail_bit <= 1'b0;
                    cnt      <= '0;
                end
                SETTLE: cnt <= (cnt == SETTLE_LAST) ? '0 : cnt + CNT_W'(1);
                SAMPLE: begin
                    fail_bit <= fail_bit | EYE_MONITOR_EARLY[lane] | EYE_MONITOR_LATE[lane];
                    cnt      <= cnt + CNT_W'(1);
                end
                STEP:   tap <= tap + TAP_W'(1);
                CENTER_LOAD: begin
                    pos      <= '0;
                    move_gap <= 1'b0;
                    if (best_len == '0) begin
                        LANE_FAIL[lane]                <= 1'b1;
                        LANE_TAP[lane*TAP_W +: TAP_W]  <= '0;
                    end else begin
                        centre <= TAP_W'(centre_tap(CALC_W'(best_start), (CALC_W+1)'(best_len)));
                    end
                end
                CENTER_MOVE: begin
                    if (pos == centre) begin
                        LANE_TAP[lane*TAP_W +: TAP_W] <= centre;
                    end else begin
                        if (!move_gap) pos <= pos + TAP_W'(1);
                        move_gap <= ~move_gap;
                    end
                end
                NEXT:   if (lane != LAST_LANE) lane <= lane + LANE_W'(1);
                default: ;
            endcase
        end
    end

    assign lane_mask               = NUM_LANES'(1) << lane;
    assign DELAY_LINE_MOVE         = move_pulse  ? lane_mask : '0;
    assign DELAY_LINE_LOAD         = load_pulse  ? lane_mask : '0;
    assign EYE_MONITOR_CLEAR_FLAGS = clear_pulse ? lane_mask : '0;
    assign DELAY_LINE_DIRECTION    = '1;
    assign BUSY                    = (state != IDLE);
    assign DONE                    = (state == FIN);

endmodule
